// File: rtl/decode_stage.sv
// decode_stage: handshaked instruction decode that resolves immediate, direct and indirect operands.
// Build option: define DECODE_ERR_EN to add ErrorOutput, a sticky flag for the reserved addressing mode.
`timescale 1ns/1ps
module decode_stage #(
    parameter int OPC_W  = 5,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic              ClockInput,
    input  logic              ResetNInput,
    input  logic              InstrValidInput,
    output logic              InstrReadyOutput,
    input  logic [OPC_W-1:0]  OpecodeInput,
    input  logic [1:0]        AddressingModeInput,
    input  logic [DATA_W-1:0] OperandInput,
    output logic              MemReqOutput,
    output logic [ADDR_W-1:0] MemAddrOutput,
    input  logic              MemAckInput,
    input  logic [DATA_W-1:0] MemDataInput,
    output logic              OutValidOutput,
    input  logic              OutReadyInput,
    output logic [OPC_W-1:0]  OpecodeOutput,
    output logic [DATA_W-1:0] OperandOutput,
    output logic [SEL_W-1:0]  OutputSelectorOutput,
    output logic              AccReadFlagOutput
`ifdef DECODE_ERR_EN
    ,
    output logic              ErrorOutput
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH1 = 2'd1,
        ST_FETCH2 = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_DIRECT   = 2'd1;
    localparam logic [1:0] MODE_INDIRECT = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // Opcodes with a clear MSB read the accumulator, except the all-zero opcode.
    function automatic logic acc_read_f(input logic [OPC_W-1:0] opc);
        acc_read_f = (opc[OPC_W-1] == 1'b0) && (opc != {OPC_W{1'b0}});
    endfunction

    function automatic logic [SEL_W-1:0] out_sel_f(input logic [OPC_W-1:0] opc);
        if (opc[OPC_W-1] == 1'b0) begin
            out_sel_f = opc[SEL_W-1:0];
        end else begin
            out_sel_f = {SEL_W{1'b0}};
        end
    endfunction

    state_e              state_q,     state_d;
    logic                indirect_q,  indirect_d;
    logic                mem_req_q,   mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                out_valid_q, out_valid_d;
    logic [OPC_W-1:0]    opcode_q,    opcode_d;
    logic [DATA_W-1:0]   operand_q,   operand_d;
    logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
    logic                acc_read_q,  acc_read_d;
`ifdef DECODE_ERR_EN
    logic                error_q,     error_d;
`endif

    logic                instr_ready_s;
    logic                accept_s;

    assign instr_ready_s = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && OutReadyInput);
    assign accept_s      = InstrValidInput && instr_ready_s;

    // Next-state and next-output computation for the decode FSM.
    always_comb begin
        state_d     = state_q;
        indirect_d  = indirect_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        out_sel_d   = out_sel_q;
        acc_read_d  = acc_read_q;
`ifdef DECODE_ERR_EN
        error_d     = error_q;
`endif

        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
            end
            ST_FETCH1: begin
                if (MemAckInput) begin
                    if (indirect_q) begin
                        state_d    = ST_FETCH2;
                        mem_addr_d = MemDataInput[ADDR_W-1:0];
                    end else begin
                        state_d     = ST_HOLD;
                        mem_req_d   = 1'b0;
                        out_valid_d = 1'b1;
                        operand_d   = MemDataInput;
                    end
                end else begin
                    state_d = ST_FETCH1;
                end
            end
            ST_FETCH2: begin
                if (MemAckInput) begin
                    state_d     = ST_HOLD;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    operand_d   = MemDataInput;
                end else begin
                    state_d = ST_FETCH2;
                end
            end
            ST_HOLD: begin
                if (OutReadyInput) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_req_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase

        // A new instruction overrides the idle/retire decision so a stream of immediates never bubbles.
        if (accept_s) begin
            opcode_d   = OpecodeInput;
            out_sel_d  = out_sel_f(OpecodeInput);
            acc_read_d = acc_read_f(OpecodeInput);
            indirect_d = (AddressingModeInput == MODE_INDIRECT);
            case (AddressingModeInput)
                MODE_DIRECT, MODE_INDIRECT: begin
                    state_d     = ST_FETCH1;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = OperandInput[ADDR_W-1:0];
                    out_valid_d = 1'b0;
                end
                default: begin
                    state_d     = ST_HOLD;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    operand_d   = OperandInput;
                end
            endcase
`ifdef DECODE_ERR_EN
            if (AddressingModeInput == MODE_RESERVED) begin
                error_d = 1'b1;
            end else begin
                error_d = error_q;
            end
`endif
        end else begin
            indirect_d = indirect_q;
        end
    end

    // State and registered outputs; reset abandons any in-flight fetch at once.
    always_ff @(posedge ClockInput or negedge ResetNInput) begin
        if (!ResetNInput) begin
            state_q     <= ST_IDLE;
            indirect_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            out_valid_q <= 1'b0;
            opcode_q    <= {OPC_W{1'b0}};
            operand_q   <= {DATA_W{1'b0}};
            out_sel_q   <= {SEL_W{1'b0}};
            acc_read_q  <= 1'b0;
`ifdef DECODE_ERR_EN
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            indirect_q  <= indirect_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            out_sel_q   <= out_sel_d;
            acc_read_q  <= acc_read_d;
`ifdef DECODE_ERR_EN
            error_q     <= error_d;
`endif
        end
    end

    assign InstrReadyOutput     = instr_ready_s;
    assign MemReqOutput         = mem_req_q;
    assign MemAddrOutput        = mem_addr_q;
    assign OutValidOutput       = out_valid_q;
    assign OpecodeOutput        = opcode_q;
    assign OperandOutput        = operand_q;
    assign OutputSelectorOutput = out_sel_q;
    assign AccReadFlagOutput    = acc_read_q;
`ifdef DECODE_ERR_EN
    assign ErrorOutput          = error_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected results, memory responder, per-scenario tasks.
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  opc_in;
    logic [1:0]  mode_in;
    logic [15:0] operand_in;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  opc_out;
    logic [15:0] operand_out;
    logic [2:0]  sel_out;
    logic        acc_out;
`ifdef DECODE_ERR_EN
    logic        err_out;
`endif

    typedef struct packed {
        logic [4:0]  opc;
        logic [15:0] operand;
        logic [2:0]  sel;
        logic        acc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem [256];
    bit          resp_en = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        inject_ack = 1'b0;
    logic [15:0] inject_data = 16'h0000;

    decode_stage #(.OPC_W(5), .DATA_W(16), .ADDR_W(8), .SEL_W(3)) dut (
        .ClockInput(clk),
        .ResetNInput(rst_n),
        .InstrValidInput(instr_valid),
        .InstrReadyOutput(instr_ready),
        .OpecodeInput(opc_in),
        .AddressingModeInput(mode_in),
        .OperandInput(operand_in),
        .MemReqOutput(mem_req),
        .MemAddrOutput(mem_addr),
        .MemAckInput(mem_ack),
        .MemDataInput(mem_data),
        .OutValidOutput(out_valid),
        .OutReadyInput(out_ready),
        .OpecodeOutput(opc_out),
        .OperandOutput(operand_out),
        .OutputSelectorOutput(sel_out),
        .AccReadFlagOutput(acc_out)
`ifdef DECODE_ERR_EN
        ,
        .ErrorOutput(err_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Data memory: acks ack_delay cycles after the request is seen, or replays injected values.
    initial begin
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                mem_ack  = inject_ack;
                mem_data = inject_data;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = mem[mem_addr];
                    wait_cnt = 0;
                end else begin
                    mem_ack  = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    function automatic exp_t make_exp(input logic [4:0] opc, input logic [15:0] op);
        exp_t e;
        e.opc     = opc;
        e.operand = op;
        e.sel     = opc[4] ? 3'd0 : opc[2:0];
        e.acc     = !opc[4] && (opc != 5'd0);
        return e;
    endfunction

    // Presents one instruction and holds it until accepted (bounded); returns just after the accepting edge.
    task automatic send(input logic [4:0] opc, input logic [1:0] mode, input logic [15:0] op,
                        input logic [15:0] exp_op, input bit push);
        if (push) sb.push_back(make_exp(opc, exp_op));
        instr_valid = 1'b1;
        opc_in      = opc;
        mode_in     = mode;
        operand_in  = op;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (instr_ready) break;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b req=%b valid=%b, expected 1 0 0", instr_ready, mem_req, out_valid);
        end
        checks++;
        if ({opc_out, operand_out, sel_out, acc_out, mem_addr} !== 33'd0) begin
            errors++;
            $display("FAIL reset_data: opc=%h op=%h sel=%h acc=%b addr=%h, expected all 0",
                     opc_out, operand_out, sel_out, acc_out, mem_addr);
        end
`ifdef DECODE_ERR_EN
        checks++;
        if (err_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err=%b, expected 0", err_out);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_immediate();
        logic [4:0]  opcs [3];
        logic [15:0] ops [3];
        exp_t e;
        opcs = '{5'b00011, 5'b10110, 5'b00000};
        ops  = '{16'h0000, 16'hA5A5, 16'hFFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(opcs[i], 2'd0, ops[i], ops[i], 1'b1);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL imm_latency[%0d]: valid=%b, expected 1", i, out_valid);
            end
            e = sb.pop_front();
            checks++;
            if ({opc_out, operand_out, sel_out, acc_out} !== e) begin
                errors++;
                $display("FAIL imm_data[%0d]: got opc=%h op=%h sel=%h acc=%b, expected opc=%h op=%h sel=%h acc=%b",
                         i, opc_out, operand_out, sel_out, acc_out, e.opc, e.operand, e.sel, e.acc);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL imm_idle: valid=%b ready=%b, expected 0 1", out_valid, instr_ready);
        end
    endtask

    task automatic test_direct();
        int   n;
        int   req_cycles;
        bit   addr_ok;
        exp_t e;
        out_ready = 1'b1;
        ack_delay = 2;
        send(5'b00101, 2'd1, 16'h0012, 16'hBEEF, 1'b1);
        n = 0; req_cycles = 0; addr_ok = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mem_req) begin
                req_cycles++;
                if (mem_addr !== 8'h12) addr_ok = 1'b0;
            end
            if (out_valid) break;
        end
        checks++;
        if (req_cycles != 3 || !addr_ok) begin
            errors++;
            $display("FAIL dir_req: req_cycles=%0d addr_ok=%0b, expected 3 1", req_cycles, addr_ok);
        end
        checks++;
        if (n != 4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL dir_latency: cycles=%0d valid=%b, expected 4 1", n, out_valid);
        end
        e = sb.pop_front();
        checks++;
        if ({opc_out, operand_out, sel_out, acc_out} !== e) begin
            errors++;
            $display("FAIL dir_data: got opc=%h op=%h sel=%h acc=%b, expected opc=%h op=%h sel=%h acc=%b",
                     opc_out, operand_out, sel_out, acc_out, e.opc, e.operand, e.sel, e.acc);
        end
        @(posedge clk);
        #1;
        // Zero-latency ack and an address whose upper operand bits must be dropped.
        ack_delay = 0;
        send(5'b01000, 2'd1, 16'hFF33, 16'h5A5A, 1'b1);
        n = 0; addr_ok = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (mem_req && mem_addr !== 8'h33) addr_ok = 1'b0;
            if (out_valid) break;
        end
        checks++;
        if (n != 2 || !addr_ok) begin
            errors++;
            $display("FAIL dir_min_latency: cycles=%0d addr_ok=%0b, expected 2 1", n, addr_ok);
        end
        e = sb.pop_front();
        checks++;
        if ({opc_out, operand_out, sel_out, acc_out} !== e) begin
            errors++;
            $display("FAIL dir_trunc_data: got opc=%h op=%h sel=%h acc=%b, expected opc=%h op=%h sel=%h acc=%b",
                     opc_out, operand_out, sel_out, acc_out, e.opc, e.operand, e.sel, e.acc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_indirect();
        logic [15:0] ops [2];
        logic [15:0] res [2];
        logic [7:0]  a0 [2];
        logic [7:0]  a1 [2];
        int          lat [2];
        int          n;
        logic [7:0]  addrs[$];
        exp_t        e;
        ops = '{16'h0040, 16'h12A0};
        res = '{16'h1234, 16'h0F0F};
        a0  = '{8'h40, 8'hA0};
        a1  = '{8'h77, 8'hC5};
        lat = '{5, 3};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ack_delay = 1 - i;
            addrs.delete();
            send(5'b00111, 2'd2, ops[i], res[i], 1'b1);
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                if (mem_req && (addrs.size() == 0 || addrs[addrs.size()-1] !== mem_addr))
                    addrs.push_back(mem_addr);
                if (out_valid) break;
            end
            checks++;
            if (addrs.size() != 2 || addrs[0] !== a0[i] || addrs[1] !== a1[i]) begin
                errors++;
                $display("FAIL ind_addrs[%0d]: count=%0d first=%h, expected 2 addrs %h then %h",
                         i, addrs.size(), (addrs.size() > 0) ? addrs[0] : 8'h00, a0[i], a1[i]);
            end
            checks++;
            if (n != lat[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL ind_latency[%0d]: cycles=%0d valid=%b, expected %0d 1", i, n, out_valid, lat[i]);
            end
            e = sb.pop_front();
            checks++;
            if ({opc_out, operand_out, sel_out, acc_out} !== e) begin
                errors++;
                $display("FAIL ind_data[%0d]: got opc=%h op=%h sel=%h acc=%b, expected opc=%h op=%h sel=%h acc=%b",
                         i, opc_out, operand_out, sel_out, acc_out, e.opc, e.operand, e.sel, e.acc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  opcs [4];
        logic [15:0] ops [4];
        logic [24:0] snap;
        exp_t        e;
        int          n;
        opcs = '{5'b00001, 5'b00010, 5'b10011, 5'b00100};
        ops  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(opcs[i], 2'd0, ops[i], ops[i], 1'b1);
            end
            begin
                n = 0;
                while (n < 10 && out_valid !== 1'b1) begin
                    @(negedge clk);
                    n++;
                end
                snap = {opc_out, operand_out, sel_out, acc_out};
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (out_valid !== 1'b1 || instr_ready !== 1'b0 || {opc_out, operand_out, sel_out, acc_out} !== snap) begin
                        errors++;
                        $display("FAIL b2b_stall[%0d]: valid=%b ready=%b out=%h, expected 1 0 %h",
                                 j, out_valid, instr_ready, {opc_out, operand_out, sel_out, acc_out}, snap);
                    end
                    if (j < 2) @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    e = sb.pop_front();
                    checks++;
                    if (out_valid !== 1'b1 || {opc_out, operand_out, sel_out, acc_out} !== e) begin
                        errors++;
                        $display("FAIL b2b_stream[%0d]: valid=%b opc=%h op=%h, expected 1 opc=%h op=%h",
                                 k, out_valid, opc_out, operand_out, e.opc, e.operand);
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b pending=%0d, expected 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_reset_in_fetch();
        out_ready = 1'b1;
        ack_delay = 10;
        send(5'b00001, 2'd1, 16'h0055, 16'h0000, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_fetch_pre: req=%b, expected 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || {opc_out, operand_out, sel_out, acc_out, mem_addr} !== 33'd0) begin
            errors++;
            $display("FAIL rst_fetch_async: req=%b valid=%b opc=%h op=%h addr=%h, expected all 0",
                     mem_req, out_valid, opc_out, operand_out, mem_addr);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        resp_en = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_fetch_ready: ready=%b, expected 1", instr_ready);
        end
        inject_data = 16'hDEAD;
        inject_ack  = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || instr_ready !== 1'b1 || operand_out !== 16'h0000) begin
            errors++;
            $display("FAIL rst_late_ack: req=%b valid=%b ready=%b op=%h, expected 0 0 1 0000",
                     mem_req, out_valid, instr_ready, operand_out);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_reserved_mode();
        exp_t e;
        out_ready = 1'b1;
`ifdef DECODE_ERR_EN
        @(negedge clk);
        checks++;
        if (err_out !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: err=%b, expected 0", err_out);
        end
`endif
        send(5'b10001, 2'd3, 16'h5A3C, 16'h5A3C, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {opc_out, operand_out, sel_out, acc_out} !== e) begin
            errors++;
            $display("FAIL mode3_data: valid=%b opc=%h op=%h sel=%h acc=%b, expected 1 opc=%h op=%h sel=%h acc=%b",
                     out_valid, opc_out, operand_out, sel_out, acc_out, e.opc, e.operand, e.sel, e.acc);
        end
`ifdef DECODE_ERR_EN
        checks++;
        if (err_out !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, expected 1", err_out);
        end
`endif
        @(posedge clk);
        #1;
        send(5'b00010, 2'd0, 16'h0001, 16'h0001, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {opc_out, operand_out, sel_out, acc_out} !== e) begin
            errors++;
            $display("FAIL mode3_next: valid=%b opc=%h op=%h, expected 1 opc=%h op=%h",
                     out_valid, opc_out, operand_out, e.opc, e.operand);
        end
`ifdef DECODE_ERR_EN
        checks++;
        if (err_out !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, expected 1", err_out);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opc_in      = 5'd0;
        mode_in     = 2'd0;
        operand_in  = 16'h0000;
        out_ready   = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[8'h12] = 16'hBEEF;
        mem[8'h33] = 16'h5A5A;
        mem[8'h40] = 16'h0077;
        mem[8'h77] = 16'h1234;
        mem[8'hA0] = 16'hFFC5;
        mem[8'hC5] = 16'h0F0F;

        test_reset();
        test_immediate();
        test_direct();
        test_indirect();
        test_back_to_back();
        test_reset_in_fetch();
        test_reserved_mode();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
